// File: rtl/ft245_fifo_bridge.sv
// FT245 USB FIFO bridge: rx/tx byte FIFOs plus a strobe-timing FSM that arbitrates the bus.
// Define FT245_HEX7SEG_EN to add a 7-segment view of the last received low nibble on seg.
module ft245_fifo_bridge #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RD_PULSE = 3,
  parameter int unsigned WR_PULSE = 2,
  parameter int unsigned RECOVER  = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  input  logic          _rdf,
  input  logic          _txe,
  input  logic [7:0]    d_in,
  output logic [7:0]    d_out,
  output logic          d_oe,
  output logic          _rd,
  output logic          wr,
  output logic [LW-1:0] tx_level,
  output logic [LW-1:0] rx_level
`ifdef FT245_HEX7SEG_EN
  ,
  output logic [7:0]    seg
`endif
);

  localparam int unsigned MaxRw  = (RD_PULSE > WR_PULSE) ? RD_PULSE : WR_PULSE;
  localparam int unsigned MaxCnt = (MaxRw > RECOVER) ? MaxRw : RECOVER;
  localparam int unsigned CW     = $clog2(MaxCnt + 1);

  typedef enum logic [2:0] {
    StIdle, StRdStrobe, StWrSetup, StWrStrobe, StWrHold, StRecover
  } state_e;

  // Flag synchronisers, preset inactive so nothing fires straight out of reset
  logic rdf_q1, rdf_s, txe_q1, txe_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdf_q1 <= 1'b1;
      rdf_s  <= 1'b1;
      txe_q1 <= 1'b1;
      txe_s  <= 1'b1;
    end else begin
      rdf_q1 <= _rdf;
      rdf_s  <= rdf_q1;
      txe_q1 <= _txe;
      txe_s  <= txe_q1;
    end
  end

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [LW-1:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic          tx_pop_req, rx_push_req;
  logic [7:0]    tx_head;

  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign tx_full  = ((tx_wptr_q ^ tx_rptr_q) == LW'(DEPTH));
  assign rx_full  = ((rx_wptr_q ^ rx_rptr_q) == LW'(DEPTH));

  assign tx_push = tx_valid && !tx_full;
  assign tx_pop  = tx_pop_req && !tx_empty;
  assign rx_push = rx_push_req && !rx_full;
  assign rx_pop  = rx_ready && !rx_empty;

  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;
  assign tx_head  = tx_mem[tx_rptr_q[AW-1:0]];
  assign rx_data  = rx_mem[rx_rptr_q[AW-1:0]];
  assign tx_level = tx_wptr_q - tx_rptr_q;
  assign rx_level = rx_wptr_q - rx_rptr_q;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q[AW-1:0]] <= tx_data;
    if (rx_push) rx_mem[rx_wptr_q[AW-1:0]] <= d_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
    end
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_n_q, rd_n_d, wr_q, wr_d, d_oe_q, d_oe_d, last_rd_q, last_rd_d;
  logic [7:0]    d_out_q, d_out_d;
  logic          rd_ok, wr_ok;

  assign rd_ok = !rdf_s && !rx_full;
  assign wr_ok = !txe_s && !tx_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rd_n_q    <= 1'b1;
      wr_q      <= 1'b0;
      d_oe_q    <= 1'b0;
      d_out_q   <= 8'h00;
      last_rd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_n_q    <= rd_n_d;
      wr_q      <= wr_d;
      d_oe_q    <= d_oe_d;
      d_out_q   <= d_out_d;
      last_rd_q <= last_rd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_n_d      = rd_n_q;
    wr_d        = wr_q;
    d_oe_d      = d_oe_q;
    d_out_d     = d_out_q;
    last_rd_d   = last_rd_q;
    rx_push_req = 1'b0;
    tx_pop_req  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        // On contention the direction not served last goes first
        if (rd_ok && (!wr_ok || !last_rd_q)) begin
          rd_n_d  = 1'b0;
          state_d = StRdStrobe;
        end else if (wr_ok) begin
          d_out_d = tx_head;
          d_oe_d  = 1'b1;
          state_d = StWrSetup;
        end
      end
      StRdStrobe: begin
        if (cnt_q == CW'(RD_PULSE - 1)) begin
          rx_push_req = 1'b1;
          rd_n_d      = 1'b1;
          last_rd_d   = 1'b1;
          cnt_d       = '0;
          state_d     = StRecover;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWrSetup: begin
        wr_d    = 1'b1;
        cnt_d   = '0;
        state_d = StWrStrobe;
      end
      StWrStrobe: begin
        if (cnt_q == CW'(WR_PULSE - 1)) begin
          wr_d    = 1'b0;
          state_d = StWrHold;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWrHold: begin
        tx_pop_req = 1'b1;
        d_oe_d     = 1'b0;
        last_rd_d  = 1'b0;
        cnt_d      = '0;
        state_d    = StRecover;
      end
      StRecover: begin
        if (cnt_q == CW'(RECOVER - 1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign _rd   = rd_n_q;
  assign wr    = wr_q;
  assign d_oe  = d_oe_q;
  assign d_out = d_out_q;

`ifdef FT245_HEX7SEG_EN
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h7E;  4'h1: p = 7'h30;  4'h2: p = 7'h6D;  4'h3: p = 7'h79;
      4'h4: p = 7'h33;  4'h5: p = 7'h5B;  4'h6: p = 7'h5F;  4'h7: p = 7'h70;
      4'h8: p = 7'h7F;  4'h9: p = 7'h7B;  4'hA: p = 7'h77;  4'hB: p = 7'h1F;
      4'hC: p = 7'h4E;  4'hD: p = 7'h3D;  4'hE: p = 7'h4F;  default: p = 7'h47;
    endcase
    return p;
  endfunction

  logic [6:0] seg_q;
  logic       seg_txe_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q     <= 7'h7E;
      seg_txe_q <= 1'b1;
    end else begin
      seg_txe_q <= txe_s;
      if (rx_push) seg_q <= hex7(d_in[3:0]);
    end
  end

  assign seg = {seg_txe_q, seg_q};
`endif

endmodule

// File: tb/tb_ft245_fifo_bridge.sv
// Directed bench for ft245_fifo_bridge: strobe timing, arbitration, rx back-pressure and reset abort.
// With FT245_HEX7SEG_EN defined it also checks the seg output.
module tb_ft245_fifo_bridge;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data, rx_data, d_in, d_out;
  logic       tx_valid, tx_ready, rx_valid, rx_ready;
  logic       rdf_n, txe_n, d_oe, rd_n, wr;
  logic [2:0] tx_level, rx_level;
`ifdef FT245_HEX7SEG_EN
  logic [7:0] seg;
`endif

  ft245_fifo_bridge #(
    .DEPTH(4), .RD_PULSE(3), .WR_PULSE(2), .RECOVER(2)
  ) dut (
    .clk(clk), .reset(reset),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    ._rdf(rdf_n), ._txe(txe_n), .d_in(d_in), .d_out(d_out), .d_oe(d_oe),
    ._rd(rd_n), .wr(wr), .tx_level(tx_level), .rx_level(rx_level)
`ifdef FT245_HEX7SEG_EN
    , .seg(seg)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd_low(input string tag);
    int n = 0;
    while (rd_n !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    check(tag, rd_n, 0);
  endtask

  task automatic count_rd_low(output int n);
    n = 0;
    while (rd_n === 1'b0 && n < 20) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, ev, bad;
    logic [3:0] seq;
    logic prev_rd, prev_wr;

    reset = 1'b1; tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
    rdf_n = 1'b1; txe_n = 1'b1; d_in = 8'h00;
    repeat (3) tick();
    check("rst_rd", rd_n, 1);
    check("rst_wr", wr, 0);
    check("rst_oe", d_oe, 0);
    check("rst_dout", d_out, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_levels", {tx_level, rx_level}, 0);
`ifdef FT245_HEX7SEG_EN
    check("rst_seg", seg, 8'hFE);
`endif
    reset = 1'b0;
    tick();

    // Single reads and the recovery gap
    rdf_n = 1'b0; d_in = 8'h41;
    wait_rd_low("t1_start");
    count_rd_low(n);
    check("t1_rd_width", n, 3);
    check("t1_rx_valid", rx_valid, 1);
    check("t1_rx_data", rx_data, 8'h41);
    check("t1_rx_level", rx_level, 1);
    n = 0;
    while (rd_n === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    check("t1_gap_ge2", n >= 2, 1);
    count_rd_low(n);
    check("t1_rd_width2", n, 3);
    rdf_n = 1'b1;
    repeat (10) tick();
    check("t1_rx_level2", rx_level, 2);
    rx_ready = 1'b1;
    check("t1_pop0", rx_data, 8'h41);
    tick();
    check("t1_pop1", rx_data, 8'h41);
    tick();
    rx_ready = 1'b0;
    check("t1_empty", rx_valid, 0);

    // Single write
    tx_data = 8'h24; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check("t2_tx_level1", tx_level, 1);
    txe_n = 1'b0;
    n = 0;
    while (d_oe !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("t2_oe", d_oe, 1);
    check("t2_setup_wr", wr, 0);
    check("t2_dout", d_out, 8'h24);
    tick();
    n = 0;
    while (wr === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    check("t2_wr_width", n, 2);
    check("t2_hold_oe", d_oe, 1);
    check("t2_hold_dout", d_out, 8'h24);
    tick();
    check("t2_oe_off", d_oe, 0);
    check("t2_tx_level0", tx_level, 0);
    txe_n = 1'b1;

    // Alternating arbitration; the write just done means rx wins first
    tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_data = 8'(8'hA0 + i);
      tick();
    end
    tx_valid = 1'b0;
    d_in = 8'h55; rdf_n = 1'b0; txe_n = 1'b0;
    seq = 4'b0; ev = 0; bad = 0; prev_rd = rd_n; prev_wr = wr;
    for (int c = 0; c < 200 && ev < 4; c++) begin
      tick();
      if (d_oe && !rd_n) bad++;
      if (prev_rd && !rd_n) begin seq = {seq[2:0], 1'b1}; ev++; end
      if (!prev_wr && wr) begin seq = {seq[2:0], 1'b0}; ev++; end
      prev_rd = rd_n;
      prev_wr = wr;
    end
    rdf_n = 1'b1; txe_n = 1'b1;
    check("t3_events", ev, 4);
    check("t3_order", seq, 4'b1010);
    repeat (20) begin
      tick();
      if (d_oe && !rd_n) bad++;
    end
    check("t3_overlap", bad, 0);
    check("t3_rx_level", rx_level, 2);
    check("t3_tx_level", tx_level, 1);
    rx_ready = 1'b1;
    repeat (2) tick();
    rx_ready = 1'b0;
    txe_n = 1'b0;
    n = 0;
    while (d_oe !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("t3_last_dout", d_out, 8'hA2);
    txe_n = 1'b1;
    repeat (15) tick();
    check("t3_tx_drained", tx_level, 0);

    // rx back-pressure
    check("t4_rx_empty", rx_level, 0);
    rdf_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_rd_low("t4_fill");
      d_in = 8'(8'h10 + k);
      count_rd_low(n);
    end
    check("t4_full_level", rx_level, 4);
    n = 0;
    repeat (30) begin
      prev_rd = rd_n;
      tick();
      if (prev_rd && !rd_n) n++;
    end
    check("t4_no_strobe_full", n, 0);
    check("t4_head", rx_data, 8'h10);
    d_in = 8'h14; rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    n = 0;
    repeat (30) begin
      prev_rd = rd_n;
      tick();
      if (prev_rd && !rd_n) n++;
    end
    check("t4_one_strobe", n, 1);
    rdf_n = 1'b1;
    repeat (5) tick();
    check("t4_refull", rx_level, 4);
    rx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t4_order", rx_data, 8'(8'h11 + k));
      tick();
    end
    rx_ready = 1'b0;

    // Reset during the second low cycle of _rd
    rdf_n = 1'b0; d_in = 8'h77;
    wait_rd_low("t5_start");
    tick();
    check("t5_mid_low", rd_n, 0);
    reset = 1'b1;
    #1;
    check("t5_rd_idle", rd_n, 1);
    check("t5_wr_idle", wr, 0);
    check("t5_oe_off", d_oe, 0);
    check("t5_rx_level", rx_level, 0);
    rdf_n = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) tick();
    check("t5_no_push", rx_valid, 0);
    check("t5_rd_still_idle", rd_n, 1);

`ifdef FT245_HEX7SEG_EN
    rdf_n = 1'b0; d_in = 8'h3A;
    wait_rd_low("seg_start");
    count_rd_low(n);
    rdf_n = 1'b1;
    tick();
    check("seg_rx_data", rx_data, 8'h3A);
    check("seg_value", seg, 8'hF7);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
